// File: rtl/usb_rx_stp_if.sv
// ============================================================================
// Module  : usb_rx_stp_if
// Brief   : Bit-level receive bus between the line monitor and usb_rx_stp.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_rx_stp_if;
  logic       d_bit;
  logic       shift_en;
  logic       eop;
  logic [7:0] rx_byte;
  logic       byte_ready;
  logic       sync_found;
  logic       stuff_err;
  logic       align_err;
  logic       pkt_active;

  // Line-monitor side: drives decoded bits and strobes.
  modport master (
    output d_bit, shift_en, eop,
    input  rx_byte, byte_ready, sync_found, stuff_err, align_err, pkt_active
  );

  // Receiver side.
  modport slave (
    input  d_bit, shift_en, eop,
    output rx_byte, byte_ready, sync_found, stuff_err, align_err, pkt_active
  );
endinterface

`default_nettype wire

// File: rtl/usb_rx_stp.sv
// ============================================================================
// Module  : usb_rx_stp
// Brief   : USB receive SYNC hunt, bit de-stuffing and MSB-first byte assembly.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rx_stp #(
  parameter logic [7:0] SYNC_BYTE = 8'b0000_0001,
  parameter int         STUFF_LEN = 6
) (
  input  wire logic   clk,
  input  wire logic   n_rst,
  usb_rx_stp_if.slave bus
);

  localparam int                  c_ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [c_ONES_W-1:0] c_STUFF  = c_ONES_W'(STUFF_LEN);
  localparam logic [c_ONES_W-1:0] c_ONE    = c_ONES_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_window,   w_window_nxt;
  logic [7:0]          r_asm,      w_asm_nxt;
  logic [2:0]          r_bit_cnt,  w_bit_cnt_nxt;
  logic [c_ONES_W-1:0] r_ones,     w_ones_nxt;
  logic [7:0]          r_rx_byte,  w_rx_byte_nxt;
  logic                r_byte_ready, w_byte_ready_nxt;
  logic                r_sync_found, w_sync_found_nxt;
  logic                r_stuff_err,  w_stuff_err_nxt;
  logic                r_align_err,  w_align_err_nxt;
  logic                r_pkt_active, w_pkt_active_nxt;

  logic [7:0]          w_win_shift;
  logic [7:0]          w_asm_shift;

  assign w_win_shift = {r_window[6:0], bus.d_bit};
  assign w_asm_shift = {r_asm[6:0],    bus.d_bit};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_window_nxt     = r_window;
    w_asm_nxt        = r_asm;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_ones_nxt       = r_ones;
    w_rx_byte_nxt    = r_rx_byte;
    w_byte_ready_nxt = 1'b0;
    w_sync_found_nxt = 1'b0;
    w_stuff_err_nxt  = 1'b0;
    w_align_err_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.eop) begin
          w_window_nxt = 8'h00;
        end else if (bus.shift_en) begin
          w_window_nxt = w_win_shift;
          if (w_win_shift == SYNC_BYTE) begin
            w_state_nxt      = S_RECV;
            w_sync_found_nxt = 1'b1;
            w_bit_cnt_nxt    = 3'd0;
            // The last SYNC bit is a one and already counts toward the run.
            w_ones_nxt       = c_ONE;
            w_asm_nxt        = 8'h00;
          end
        end
      end

      S_RECV: begin
        if (bus.eop) begin
          w_align_err_nxt = (r_bit_cnt != 3'd0);
          w_state_nxt     = S_IDLE;
          w_window_nxt    = 8'h00;
          w_asm_nxt       = 8'h00;
          w_bit_cnt_nxt   = 3'd0;
          w_ones_nxt      = '0;
        end else if (bus.shift_en) begin
          if (r_ones == c_STUFF) begin
            if (bus.d_bit) begin
              w_stuff_err_nxt = 1'b1;
              w_state_nxt     = S_ERR;
              w_window_nxt    = 8'h00;
              w_asm_nxt       = 8'h00;
              w_bit_cnt_nxt   = 3'd0;
              w_ones_nxt      = '0;
            end else begin
              w_ones_nxt = '0;
            end
          end else begin
            w_asm_nxt  = w_asm_shift;
            w_ones_nxt = bus.d_bit ? (r_ones + c_ONE) : '0;
            if (r_bit_cnt == 3'd7) begin
              w_bit_cnt_nxt    = 3'd0;
              w_rx_byte_nxt    = w_asm_shift;
              w_byte_ready_nxt = 1'b1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end
        end
      end

      S_ERR: begin
        if (bus.eop) begin
          w_state_nxt  = S_IDLE;
          w_window_nxt = 8'h00;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_window_nxt = 8'h00;
      end
    endcase

    w_pkt_active_nxt = (w_state_nxt == S_RECV);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_window     <= 8'h00;
      r_asm        <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_ones       <= '0;
      r_rx_byte    <= 8'h00;
      r_byte_ready <= 1'b0;
      r_sync_found <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_align_err  <= 1'b0;
      r_pkt_active <= 1'b0;
    end else begin
      r_window     <= w_window_nxt;
      r_asm        <= w_asm_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_ones       <= w_ones_nxt;
      r_rx_byte    <= w_rx_byte_nxt;
      r_byte_ready <= w_byte_ready_nxt;
      r_sync_found <= w_sync_found_nxt;
      r_stuff_err  <= w_stuff_err_nxt;
      r_align_err  <= w_align_err_nxt;
      r_pkt_active <= w_pkt_active_nxt;
    end
  end

  assign bus.rx_byte    = r_rx_byte;
  assign bus.byte_ready = r_byte_ready;
  assign bus.sync_found = r_sync_found;
  assign bus.stuff_err  = r_stuff_err;
  assign bus.align_err  = r_align_err;
  assign bus.pkt_active = r_pkt_active;

endmodule

`default_nettype wire
